grng_pair_buffer: RTL and testbench
===================================

// Module: grng_pair_buffer
// PURPOSE
//  Consumer-side front end for Id_Gaussian. Sequences the generator's reset/seed-load pulse,
//  discards warm-up samples, then captures every (G1,G2) pair into a FIFO and presents
//  them to the Heston path engine over valid/ready. Id_Gaussian is free-running and has
//  no backpressure, so pairs arriving while the FIFO is full are dropped and counted.
// PARAMETERS
//  DW      32  width of one Gaussian sample (Id_Gaussian 32-bit float format, passed through)
//  DEPTH   16  FIFO entries, power of two, >=2
//  RST_CYC 3   cycles gen_rst is held high during the seed sequence
//  WARMUP  4   cycles after the gen_en pulse whose G1/G2 are discarded
// PORTS
//  clk        in   1     clock
//  rst_n      in   1     async active-low reset
//  start      in   1     1-cycle pulse: flush FIFO, reseed generator, begin capture
//  stop       in   1     1-cycle pulse: stop capturing, return to IDLE
//  seed1_in   in   23    seed for generator seed1, sampled on start
//  seed2_in   in   23    seed for generator seed2, sampled on start
//  gen_rst    out  1     to Id_Gaussian rst (active-high)
//  gen_en     out  1     to Id_Gaussian en (seed-load strobe)
//  gen_seed1  out  23    to Id_Gaussian seed1; zero except in SEED
//  gen_seed2  out  23    to Id_Gaussian seed2; zero except in SEED
//  gen_g1     in   DW    from Id_Gaussian G1
//  gen_g2     in   DW    from Id_Gaussian G2
//  out_valid  out  1     FIFO non-empty
//  out_ready  in   1     downstream accepts pair this cycle
//  out_g1     out  DW    head-of-FIFO G1
//  out_g2     out  DW    head-of-FIFO G2
//  busy       out  1     FSM not IDLE
//  drop_cnt   out  16    pairs dropped on full FIFO; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: FSM=IDLE; gen_rst=0, gen_en=0, gen_seed*=0; FIFO empty, out_valid=0,
//   out_g1/out_g2=0; busy=0; drop_cnt=0; seed registers=0.
//  FSM: IDLE -start-> GRST (gen_rst=1 for RST_CYC cycles) -> SEED (gen_en=1,
//   gen_seed*=latched seeds, exactly 1 cycle) -> WARM (WARMUP cycles, no capture)
//   -> RUN (push {gen_g2,gen_g1} every cycle). stop in any non-IDLE state -> IDLE next
//   cycle; generator outputs then ignored. start outside IDLE ignored.
//  start in IDLE: FIFO flushed and drop_cnt cleared in the same edge; seeds latched.
//  stop and start same cycle: stop wins (in IDLE both are no-ops except start).
//  Capture: push in every RUN cycle; sample valid on the clk edge ending that cycle.
//  FIFO: first-word-fall-through; out_g* valid when out_valid=1; pop on
//   out_valid&out_ready. Pushed pair visible at out_valid the cycle after push.
//  Full: push with no pop -> pair dropped, drop_cnt+1 (saturating). Full with
//   simultaneous pop -> push accepted, no drop. Empty with pop request -> no-op.
//  Pointers log2(DEPTH)+1 bits, wrap naturally; full = MSBs differ, low bits equal.
//  stop does not flush: remaining pairs stay drainable in IDLE.
//  Reset mid-operation: immediate return to reset state, FIFO contents lost.
// STRUCTURE
//  Package grng_pkg: DW, state enum {IDLE,GRST,SEED,WARM,RUN}, SEED_W=23, CNT_W=16.
//  Sub-module grng_fifo (DW*2 wide, DEPTH deep, sync FWFT, flush input, full/empty).
//  Top holds FSM, phase counter (max(RST_CYC,WARMUP) range), seed latches, drop counter.
// TESTING (bench instantiates Id_Gaussian behind this block or a counting stub)
//  1 start, seeds 4357/232 -> gen_rst high 3 cycles, gen_en 1 cycle with seeds, then
//    first out_valid 1+WARMUP+1 cycles after gen_en falls; stub value matches out_g*.
//  2 out_ready=1 always, stub counts 1,2,3... -> out_g1 strictly sequential, drop_cnt=0.
//  3 out_ready=0 for 20 RUN cycles, DEPTH=16 -> FIFO holds first 16, drop_cnt=4; then
//    ready=1 drains 16 in order, no gaps or duplicates.
//  4 full FIFO with out_ready=1 -> no drop, occupancy stays 16.
//  5 stop mid-RUN with 5 queued -> busy=0 next cycle, 5 pairs still drain, no new pushes;
//    start again -> FIFO flushed, drop_cnt=0, new seed sequence.
//  6 rst_n low mid-WARM -> all outputs at reset values asynchronously; start works after.

Source files
------------

// File: rtl/grng_pkg.sv
// Shared types and constants for the Gaussian pair buffer.
//   DW     : width of one Gaussian sample
//   SEED_W : width of each generator seed
//   CNT_W  : width of the dropped-pair counter
//   state_t: sequencing FSM states
package grng_pkg;

   localparam int DW     = 32;
   localparam int SEED_W = 23;
   localparam int CNT_W  = 16;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      GRST = 3'd1,
      SEED = 3'd2,
      WARM = 3'd3,
      RUN  = 3'd4
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/grng_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   flush      : empties the FIFO on the next edge (wins over push/pop)
//   push, din  : write request and data; a push while full is only taken
//                when a pop happens in the same cycle
//   pop        : read request; ignored while empty
//   dout       : head entry, forced to zero while empty
//   full, empty: occupancy flags
module grng_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         wr_en;
   logic         rd_en;

   // The extra pointer bit separates full from empty when the low bits match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_en = pop && !empty;
   assign wr_en = push && !flush && (!full || rd_en);
   assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/grng_pair_buffer.sv
// Consumer-side front end for the Gaussian generator: sequences the
// generator reset and seed-load strobe, discards warm-up samples, then
// captures every (G1,G2) pair into a FIFO drained over valid/ready.
// Pairs arriving on a full FIFO are dropped and counted.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   start, stop          : 1-cycle control pulses
//   seed1_in, seed2_in   : seeds, latched on an accepted start
//   gen_rst, gen_en      : generator reset / seed-load strobe
//   gen_seed1, gen_seed2 : seeds to the generator, zero outside SEED
//   gen_g1, gen_g2       : generator samples
//   out_valid/out_ready  : output handshake, out_g1/out_g2 head pair
//   busy                 : sequencer not idle
//   drop_cnt             : saturating count of dropped pairs
//
// state | meaning
// IDLE  | no capture; FIFO still drainable
// GRST  | gen_rst held high for RST_CYC cycles
// SEED  | gen_en high one cycle with latched seeds
// WARM  | WARMUP cycles of samples discarded
// RUN   | one pair pushed every cycle
module grng_pair_buffer #(
   parameter int DW      = grng_pkg::DW,
   parameter int DEPTH   = 16,
   parameter int RST_CYC = 3,
   parameter int WARMUP  = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        stop,
   input  logic [grng_pkg::SEED_W-1:0] seed1_in,
   input  logic [grng_pkg::SEED_W-1:0] seed2_in,
   output logic                        gen_rst,
   output logic                        gen_en,
   output logic [grng_pkg::SEED_W-1:0] gen_seed1,
   output logic [grng_pkg::SEED_W-1:0] gen_seed2,
   input  logic [DW-1:0]               gen_g1,
   input  logic [DW-1:0]               gen_g2,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DW-1:0]               out_g1,
   output logic [DW-1:0]               out_g2,
   output logic                        busy,
   output logic [grng_pkg::CNT_W-1:0]  drop_cnt
);
   import grng_pkg::*;

   localparam int PH_MAX = max_int(RST_CYC, WARMUP);
   localparam int PW     = $clog2(PH_MAX + 1);

   state_t            state;
   state_t            state_nx;
   logic [PW-1:0]     phase;
   logic [PW-1:0]     phase_nx;
   logic [SEED_W-1:0] seed1_q;
   logic [SEED_W-1:0] seed2_q;
   logic              start_idle;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic              drop;
   logic [2*DW-1:0]   fifo_dout;

   assign start_idle = (state == IDLE) && start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         phase <= '0;
      end else begin
         state <= state_nx;
         phase <= phase_nx;
      end
   end

   // phase is a down-counter; each timed state ends on terminal count zero.
   always_comb begin
      state_nx = state;
      phase_nx = phase;
      case (state)
         IDLE: if (start) begin
            state_nx = GRST;
            phase_nx = PW'(RST_CYC - 1);
         end
         GRST: if (phase == '0) state_nx = SEED;
               else             phase_nx = phase - PW'(1);
         SEED: begin
            state_nx = WARM;
            phase_nx = PW'(WARMUP - 1);
         end
         WARM: if (phase == '0) state_nx = RUN;
               else             phase_nx = phase - PW'(1);
         RUN:  state_nx = RUN;
         default: state_nx = IDLE;
      endcase
      if ((state != IDLE) && stop) state_nx = IDLE;
   end

   // A stop in RUN also suppresses that cycle's capture.
   always_comb begin
      gen_rst   = 1'b0;
      gen_en    = 1'b0;
      gen_seed1 = '0;
      gen_seed2 = '0;
      push      = 1'b0;
      busy      = (state != IDLE);
      case (state)
         GRST: gen_rst = 1'b1;
         SEED: begin
            gen_en    = 1'b1;
            gen_seed1 = seed1_q;
            gen_seed2 = seed2_q;
         end
         RUN:  push = !stop;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seed1_q <= '0;
         seed2_q <= '0;
      end else if (start_idle) begin
         seed1_q <= seed1_in;
         seed2_q <= seed2_in;
      end
   end

   assign pop  = out_valid && out_ready;
   assign drop = push && full && !pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (start_idle) begin
         drop_cnt <= '0;
      end else if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end

   grng_fifo #(
      .W     (2 * DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (start_idle),
      .push  (push),
      .din   ({gen_g2, gen_g1}),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty)
   );

   assign out_valid = !empty;
   assign out_g1    = fifo_dout[DW-1:0];
   assign out_g2    = fifo_dout[2*DW-1:DW];

endmodule

// File: tb/tb_grng_pair_buffer.sv
module tb_grng_pair_buffer;

   localparam int DEPTH   = 16;
   localparam int RST_CYC = 3;
   localparam int WARMUP  = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        out_ready = 1'b0;
   logic [22:0] seed1_in = '0;
   logic [22:0] seed2_in = '0;
   logic        gen_rst, gen_en, out_valid, busy;
   logic [22:0] gen_seed1, gen_seed2;
   logic [31:0] gen_g1, gen_g2, out_g1, out_g2;
   logic [15:0] drop_cnt;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   grng_pair_buffer #(.DW(32), .DEPTH(DEPTH), .RST_CYC(RST_CYC), .WARMUP(WARMUP)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .seed1_in(seed1_in), .seed2_in(seed2_in),
      .gen_rst(gen_rst), .gen_en(gen_en),
      .gen_seed1(gen_seed1), .gen_seed2(gen_seed2),
      .gen_g1(gen_g1), .gen_g2(gen_g2),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_g1(out_g1), .out_g2(out_g2),
      .busy(busy), .drop_cnt(drop_cnt)
   );

   // Counting generator stub: cleared by gen_rst, loads seed1 on gen_en.
   logic [31:0] stub_cnt = '0;
   always @(posedge clk) begin
      if (gen_rst)     stub_cnt <= '0;
      else if (gen_en) stub_cnt <= {9'd0, gen_seed1};
      else             stub_cnt <= stub_cnt + 1;
   end
   assign gen_g1 = stub_cnt;
   assign gen_g2 = (stub_cnt * 32'd3) ^ 32'hA5A5_0000;

   // Reference model: time since start decides the phase; a queue is the FIFO.
   logic [63:0] mq[$];
   bit          m_active = 0;
   int          m_age = 0;
   int          m_drops = 0;
   logic [22:0] m_s1 = '0;
   logic [22:0] m_s2 = '0;
   bit          m_pop, m_push;

   always @(posedge clk) begin
      if (rst_n) begin
         m_pop  = (mq.size() > 0) && out_ready;
         m_push = m_active && !stop && (m_age >= RST_CYC + 1 + WARMUP);
         if (m_pop) void'(mq.pop_front());
         if (m_push) begin
            if (mq.size() < DEPTH) mq.push_back({gen_g2, gen_g1});
            else if (m_drops < 65535) m_drops++;
         end
         if (!m_active) begin
            if (start) begin
               mq.delete();
               m_drops  = 0;
               m_active = 1;
               m_age    = 0;
               m_s1     = seed1_in;
               m_s2     = seed2_in;
            end
         end else if (stop) begin
            m_active = 0;
         end else begin
            m_age++;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      logic [63:0] head;
      bit          en_exp;
      head   = (mq.size() > 0) ? mq[0] : 64'd0;
      en_exp = m_active && (m_age == RST_CYC);
      chk("out_valid", out_valid, mq.size() > 0);
      chk("out_g1", out_g1, head[31:0]);
      chk("out_g2", out_g2, head[63:32]);
      chk("busy", busy, m_active);
      chk("drop_cnt", drop_cnt, m_drops);
      chk("gen_rst", gen_rst, m_active && (m_age < RST_CYC));
      chk("gen_en", gen_en, en_exp);
      chk("gen_seed1", gen_seed1, en_exp ? m_s1 : 23'd0);
      chk("gen_seed2", gen_seed2, en_exp ? m_s2 : 23'd0);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         check_all();
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_g1"}, out_g1, 0);
      chk({tag, "_g2"}, out_g2, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_drop"}, drop_cnt, 0);
      chk({tag, "_grst"}, gen_rst, 0);
      chk({tag, "_gen"}, gen_en, 0);
      chk({tag, "_seed1"}, gen_seed1, 0);
      chk({tag, "_seed2"}, gen_seed2, 0);
   endtask

   // Start from IDLE with out_ready high and check the seed sequence timing.
   task automatic run_seq(input logic [22:0] s1, input logic [22:0] s2);
      int          n_rst = 0;
      int          n_en = 0;
      int          fall_k = -1;
      int          val_k = -1;
      logic [22:0] g1s = '0;
      logic [22:0] g2s = '0;
      logic [31:0] first_g1 = '0;
      seed1_in  = s1;
      seed2_in  = s2;
      out_ready = 1'b1;
      start     = 1'b1;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         check_all();
         if (k == 0) start = 1'b0;
         if (gen_rst) n_rst++;
         if (gen_en) begin
            n_en++;
            g1s = gen_seed1;
            g2s = gen_seed2;
         end else if (n_en > 0 && fall_k < 0) begin
            fall_k = k;
         end
         if (out_valid && val_k < 0) begin
            val_k    = k;
            first_g1 = out_g1;
         end
      end
      chk("seq_rst_cycles", n_rst, RST_CYC);
      chk("seq_en_cycles", n_en, 1);
      chk("seq_seed1", g1s, s1);
      chk("seq_seed2", g2s, s2);
      chk("seq_latency", val_k - fall_k + 1, 1 + WARMUP + 1);
      chk("seq_first_g1", first_g1, {9'd0, s1} + WARMUP);
   endtask

   initial begin
      int          n;
      logic [31:0] prev;

      // Reset values
      cyc(2);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      cyc(1);

      // Seed sequence with fixed seeds
      run_seq(23'd4357, 23'd232);

      // Steady streaming with out_ready high: strictly sequential samples
      prev = out_g1;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         chk("stream_seq", out_g1, prev + 1);
         prev = out_g1;
      end
      chk("stream_nodrop", drop_cnt, 0);

      // Random ready pattern
      for (int i = 0; i < 40; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         cyc(1);
      end

      // Overflow: 20 RUN cycles with ready low, then full with ready high
      out_ready = 1'b0;
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      seed1_in = 23'($urandom);
      seed2_in = 23'($urandom);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(8 + 20);
      chk("ovf_drop4", drop_cnt, 4);
      chk("ovf_valid", out_valid, 1);
      out_ready = 1'b1;
      cyc(10);
      chk("full_pop_nodrop", drop_cnt, 4);
      chk("full_pop_valid", out_valid, 1);

      // Stop and drain all 16 entries
      stop = 1'b1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) n++;
         cyc(1);
         if (i == 0) stop = 1'b0;
      end
      chk("drain16", n, DEPTH);
      chk("drain_busy", busy, 0);

      // Stop mid-RUN with 5 queued
      out_ready = 1'b0;
      seed1_in = 23'($urandom);
      seed2_in = 23'($urandom);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(8 + 5);
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      chk("stop_busy", busy, 0);
      chk("stop_valid", out_valid, 1);
      cyc(3);
      out_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) n++;
         cyc(1);
      end
      chk("stop_drain5", n, 5);
      chk("stop_empty", out_valid, 0);

      // Leave entries and drops behind, then restart: flush and clear
      out_ready = 1'b0;
      seed1_in = 23'($urandom);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(8 + 18);
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      cyc(2);
      chk("pre_restart_drop", drop_cnt, 2);
      seed1_in = 23'($urandom);
      seed2_in = 23'($urandom);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      chk("restart_flush", out_valid, 0);
      chk("restart_drop", drop_cnt, 0);
      chk("restart_grst", gen_rst, 1);

      // Async reset in the middle of WARM
      cyc(5);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      mq.delete();
      m_active = 0;
      m_drops  = 0;
      m_age    = 0;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      run_seq(23'($urandom), 23'($urandom));
      for (int i = 0; i < 30; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         stop = ($urandom_range(0, 15) == 0);
         cyc(1);
      end
      stop = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
